// File: rtl/obstacle_scroller_pkg.sv
// Shared game definitions: scroller state encoding, obstacle width limits
// (also used by the width generator) and the screen size.
package obstacle_scroller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    MOVE,
    SPACE
  } state_t;

  localparam int OBS_MIN_W   = 230;
  localparam int OBS_MAX_W   = 690;
  localparam int SCREEN_W_PX = 1280;

endpackage

// File: rtl/obstacle_scroller_gap_counter.sv
// Frame-tick counter for the pause between obstacles; done flags the tick
// that reaches GAP_TICKS so the scroller can leave SPACE on that edge.
module gap_counter #(
  parameter int GAP_TICKS = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int CW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(GAP_TICKS - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= (count_reg == LAST) ? '0 : count_reg + CW'(1);
    end
  end

  assign done = enable && (count_reg == LAST);

endmodule

// File: rtl/obstacle_scroller.sv
// Requests a random width, spawns an obstacle at the right screen edge and
// scrolls it left one SPEED step per frame tick, then waits a gap and repeats.
module obstacle_scroller
  import obstacle_scroller_pkg::*;
#(
  parameter int SCREEN_W  = SCREEN_W_PX,
  parameter int SPEED     = 4,
  parameter int GAP_TICKS = 30,
  parameter int PLAYER_X  = 200,
  parameter int MIN_W     = OBS_MIN_W,
  parameter int MAX_W     = OBS_MAX_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               run,
  input  logic [15:0]        rand_width,
  output logic               rand_req,
  output logic signed [15:0] obs_left,
  output logic [15:0]        obs_width,
  output logic               obs_valid,
  output logic               scored
);

  localparam logic signed [16:0] SPEED_R  = 17'(SPEED);
  localparam logic signed [16:0] PLAYER_R = 17'(PLAYER_X);
  localparam logic signed [15:0] SPEED_L  = 16'(SPEED);
  localparam logic [15:0]        SCREEN_L = 16'(SCREEN_W);
  localparam logic [15:0]        MIN_W_L  = 16'(MIN_W);
  localparam logic [15:0]        MAX_W_L  = 16'(MAX_W);

  state_t             state_reg;
  logic signed [16:0] right_reg;
  logic signed [16:0] right_next;
  logic [15:0]        width_clamped;
  logic               step_tick;
  logic               gap_done;

  assign step_tick  = frame_tick && run;
  assign right_next = right_reg - SPEED_R;

  always_comb begin
    width_clamped = rand_width;
    if (rand_width < MIN_W_L) begin
      width_clamped = MIN_W_L;
    end else if (rand_width > MAX_W_L) begin
      width_clamped = MAX_W_L;
    end
  end

  // Held clear outside SPACE, so every gap starts counting from zero.
  gap_counter #(
    .GAP_TICKS(GAP_TICKS)
  ) u_gap (
    .clk   (clk),
    .reset (reset),
    .clear (state_reg != SPACE),
    .enable(step_tick && (state_reg == SPACE)),
    .done  (gap_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      rand_req  <= 1'b0;
      obs_left  <= '0;
      obs_width <= '0;
      obs_valid <= 1'b0;
      scored    <= 1'b0;
      right_reg <= '0;
    end else begin
      rand_req <= 1'b0;
      scored   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (run) begin
            state_reg <= REQ;
            rand_req  <= 1'b1;
          end
        end
        REQ: begin
          state_reg <= LOAD;
        end
        LOAD: begin
          obs_width <= width_clamped;
          obs_left  <= SCREEN_L;
          right_reg <= $signed({1'b0, SCREEN_L}) + $signed({1'b0, width_clamped});
          obs_valid <= 1'b1;
          state_reg <= MOVE;
        end
        MOVE: begin
          if (step_tick) begin
            if (right_reg <= SPEED_R) begin
              obs_valid <= 1'b0;
              state_reg <= SPACE;
            end else begin
              obs_left  <= obs_left - SPEED_L;
              right_reg <= right_next;
              // Right edge only decreases, so this crossing happens once per obstacle.
              scored    <= (right_reg >= PLAYER_R) && (right_next < PLAYER_R);
            end
          end
        end
        SPACE: begin
          if (gap_done) begin
            state_reg <= REQ;
            rand_req  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_scroller.sv
// Directed bench for obstacle_scroller: a position-from-tick-count model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_obstacle_scroller;

  localparam int SCREEN_W  = 1280;
  localparam int SPEED     = 4;
  localparam int GAP_TICKS = 30;
  localparam int PLAYER_X  = 200;
  localparam int MIN_W     = 230;
  localparam int MAX_W     = 690;

  localparam int M_IDLE  = 0;
  localparam int M_REQ   = 1;
  localparam int M_LOAD  = 2;
  localparam int M_MOVE  = 3;
  localparam int M_SPACE = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               frame_tick = 1'b0;
  logic               run = 1'b0;
  logic [15:0]        rand_width = 16'd0;
  logic               rand_req;
  logic signed [15:0] obs_left;
  logic [15:0]        obs_width;
  logic               obs_valid;
  logic               scored;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  int m_mode = M_IDLE;
  int m_w = 0, m_n = 0, m_gap = 0, m_left = 0;
  bit m_req = 1'b0, m_valid = 1'b0, m_scored = 1'b0;

  always #5 clk = ~clk;

  obstacle_scroller #(
    .SCREEN_W (SCREEN_W),
    .SPEED    (SPEED),
    .GAP_TICKS(GAP_TICKS),
    .PLAYER_X (PLAYER_X),
    .MIN_W    (MIN_W),
    .MAX_W    (MAX_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .run       (run),
    .rand_width(rand_width),
    .rand_req  (rand_req),
    .obs_left  (obs_left),
    .obs_width (obs_width),
    .obs_valid (obs_valid),
    .scored    (scored)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_w(input int v);
    if (v < MIN_W) return MIN_W;
    if (v > MAX_W) return MAX_W;
    return v;
  endfunction

  // Position is derived from the number of accepted ticks since spawn.
  always @(posedge clk) begin : model
    int right_old;
    int right_new;
    m_req    = 1'b0;
    m_scored = 1'b0;
    if (reset) begin
      m_mode = M_IDLE; m_w = 0; m_n = 0; m_gap = 0; m_left = 0; m_valid = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: if (run) begin m_mode = M_REQ; m_req = 1'b1; end
        M_REQ:  m_mode = M_LOAD;
        M_LOAD: begin
          m_w = clamp_w(int'(rand_width)); m_n = 0; m_left = SCREEN_W;
          m_valid = 1'b1; m_mode = M_MOVE;
        end
        M_MOVE: if (frame_tick && run) begin
          right_old = SCREEN_W + m_w - SPEED * m_n;
          if (right_old <= SPEED) begin
            m_valid = 1'b0; m_gap = 0; m_mode = M_SPACE;
          end else begin
            m_n++;
            right_new = right_old - SPEED;
            m_left = SCREEN_W - SPEED * m_n;
            m_scored = (right_old >= PLAYER_X) && (right_new < PLAYER_X);
          end
        end
        M_SPACE: if (frame_tick && run) begin
          m_gap++;
          if (m_gap == GAP_TICKS) begin m_mode = M_REQ; m_req = 1'b1; end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_rand_req", int'(rand_req), int'(m_req));
      check("cyc_obs_valid", int'(obs_valid), int'(m_valid));
      check("cyc_obs_left", int'(obs_left), m_left);
      check("cyc_obs_width", int'(obs_width), m_w);
      check("cyc_scored", int'(scored), int'(m_scored));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_obs(output bit sc, output bit rq, output bit vl);
    frame_tick = 1'b1;
    step();
    sc = scored; rq = rand_req; vl = obs_valid;
    frame_tick = 1'b0;
    step();
  endtask

  task automatic run_to_drop(input int limit, output int score_tick, output int drop_tick);
    bit sc, rq, vl;
    score_tick = -1; drop_tick = -1;
    for (int t = 1; t <= limit; t++) begin
      tick_obs(sc, rq, vl);
      if (sc && score_tick < 0) score_tick = t;
      if (!vl) begin drop_tick = t; break; end
    end
  endtask

  task automatic run_gap(output int gap_tick);
    bit sc, rq, vl;
    gap_tick = -1;
    for (int g = 1; g <= 40; g++) begin
      tick_obs(sc, rq, vl);
      if (rq) begin gap_tick = g; break; end
    end
  endtask

  initial begin : stim
    bit sc, rq, vl;
    int score_tick, drop_tick, gap_tick;

    repeat (3) step();
    chk_en = 1'b1;
    check("reset_valid", int'(obs_valid), 0);
    check("reset_left", int'(obs_left), 0);
    check("reset_width", int'(obs_width), 0);
    check("reset_req", int'(rand_req), 0);
    reset = 1'b0; rand_width = 16'd330;
    step();
    check("idle_no_req", int'(rand_req), 0);

    run = 1'b1;
    step();
    check("req_pulse", int'(rand_req), 1);
    step();
    check("req_single", int'(rand_req), 0);
    step();
    check("valid_latency", int'(obs_valid), 1);
    check("spawn_left", int'(obs_left), 1280);
    check("spawn_width", int'(obs_width), 330);
    $display("obstacle 1 spawned: left=%0d width=%0d", obs_left, obs_width);

    tick_obs(sc, rq, vl);
    check("left_tick1", int'(obs_left), 1276);
    run_to_drop(500, score_tick, drop_tick);
    check("score_tick", score_tick + 1, 353);
    check("drop_tick", drop_tick + 1, 403);
    rand_width = 16'd0;
    run_gap(gap_tick);
    check("gap_ticks", gap_tick, 30);
    step();
    check("clamp_low", int'(obs_width), 230);
    check("spawn2_left", int'(obs_left), 1280);
    $display("obstacle 2 spawned: left=%0d width=%0d", obs_left, obs_width);

    repeat (5) tick_obs(sc, rq, vl);
    check("left_5ticks", int'(obs_left), 1260);
    run = 1'b0;
    repeat (10) tick_obs(sc, rq, vl);
    check("pause_left", int'(obs_left), 1260);
    check("pause_valid", int'(obs_valid), 1);
    run = 1'b1;
    tick_obs(sc, rq, vl);
    check("resume_left", int'(obs_left), 1256);

    rand_width = 16'd700;
    run_to_drop(600, score_tick, drop_tick);
    check("drop2_seen", int'(drop_tick > 0), 1);
    run_gap(gap_tick);
    check("gap2_ticks", gap_tick, 30);
    step();
    check("clamp_high", int'(obs_width), 690);
    $display("obstacle 3 spawned: left=%0d width=%0d", obs_left, obs_width);

    // Right edge is 202 here; the next tick would score, but reset wins.
    repeat (442) tick_obs(sc, rq, vl);
    check("pre_reset_left", int'(obs_left), -488);
    frame_tick = 1'b1; reset = 1'b1;
    step();
    check("mid_reset_scored", int'(scored), 0);
    check("mid_reset_valid", int'(obs_valid), 0);
    check("mid_reset_left", int'(obs_left), 0);
    check("mid_reset_width", int'(obs_width), 0);
    reset = 1'b0;
    step();
    check("req_after_reset", int'(rand_req), 1);
    step();
    step();
    frame_tick = 1'b0;
    check("tick_drop_valid", int'(obs_valid), 1);
    check("tick_drop_left", int'(obs_left), 1280);
    step();
    check("tick_drop_hold", int'(obs_left), 1280);
    tick_obs(sc, rq, vl);
    check("tick_after_drop", int'(obs_left), 1276);
    $display("obstacle 4 spawned after reset: width=%0d", obs_width);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // The first scoring / dropping tick counters above are 1 behind because
  // tick 1 is issued separately before run_to_drop.

endmodule

// File: doc/obstacle_scroller.md
# obstacle_scroller

Consumer of the random-width generator. It requests a new random obstacle width, latches it, and scrolls the obstacle from the right screen edge to the left, one step per frame tick. When the obstacle has fully left the screen, it waits a programmable gap before requesting the next one. Its outputs feed the renderer and the collision/score logic.

## Interface
Parameters:
- SCREEN_W, 1280: horizontal resolution in px; the spawn left edge.
- SPEED, 4: px moved per frame tick.
- GAP_TICKS, 30: frame ticks between one obstacle leaving and the next request.
- PLAYER_X, 200: x coordinate used for the score event.
- MIN_W, 230: lower clamp on the latched width.
- MAX_W, 690: upper clamp on the latched width.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-cycle pulse per video frame.
- run  in  1  high while the game is running; low freezes motion.
- rand_width  in  16  random_number from the width generator.
- rand_req  out  1  drives the generator's is_active; one-cycle pulse.
- obs_left  out  16  signed two's-complement left edge of the obstacle, px.
- obs_width  out  16  latched, clamped width, px.
- obs_valid  out  1  obstacle present (state MOVE).
- scored  out  1  one-cycle pulse when the right edge passes PLAYER_X.

## Operation
- Internal right edge `right` = obs_left + obs_width, held as a 17-bit signed register.
- States:
  - IDLE: obs_valid=0. Go to REQ when run=1.
  - REQ: rand_req=1 for exactly this cycle. Go to LOAD unconditionally.
  - LOAD: rand_width already holds the new value; the generator registers it on the REQ edge. Latch obs_width = clamp(rand_width, MIN_W, MAX_W). Set obs_left=SCREEN_W. Go to MOVE.
  - MOVE: obs_valid=1. On frame_tick with run=1:
    - If right <= SPEED: obs_valid drops, gap counter clears, go to SPACE.
    - Otherwise obs_left -= SPEED.
  - SPACE: obs_valid=0. Count frame_tick while run=1. On reaching GAP_TICKS, go to REQ.
- Clamping: rand_width < MIN_W (including 0 straight after the generator resets) yields MIN_W; rand_width > MAX_W yields MAX_W.
- scored: pulses on the MOVE decrement where old right >= PLAYER_X and new right < PLAYER_X. It fires at most once per obstacle.
- run=0:
  - MOVE and SPACE hold all state and ignore frame_tick.
  - REQ and LOAD always complete.
  - IDLE stays in IDLE.
- frame_tick arriving in REQ or LOAD is dropped, not queued.

## Timing
- Reset values: state=IDLE, rand_req=0, obs_left=0, obs_width=0, obs_valid=0, scored=0, gap counter=0.
- Reset has priority over all other inputs in every state, including mid-scroll. Outputs reach their reset values on the next edge.
- Latency:
  - run rising in IDLE: rand_req high the next cycle.
  - obs_valid high 2 cycles after the rand_req cycle.
- Position update: obs_left changes on the edge following a qualifying frame_tick. scored is registered in the same cycle as that update.
- All outputs are registered; there are no combinational paths from input to output.
- rand_req is never high for two consecutive cycles.

## Structure
- Shared game package holds:
  - state enum (IDLE, REQ, LOAD, MOVE, SPACE);
  - MIN_W and MAX_W width constants, shared with the width generator;
  - the screen-size constant.
- One sub-module, `gap_counter`: frame-tick counter with clear, enable and a terminal-count flag, parameterised by GAP_TICKS.
- The clamp and the edge arithmetic stay inline.

## Test plan
Default parameters unless stated.
- Reset, then run=1 with rand_width=330 -> rand_req pulses 1 cycle; 2 cycles later obs_valid=1, obs_left=1280, obs_width=330.
- Width 330, continuous frame ticks -> obs_left=1276 after tick 1; scored pulses on tick 353 (right=198); tick 403 drops obs_valid; REQ follows 30 ticks later.
- rand_width=0 -> obs_width=230. rand_width=700 -> obs_width=690.
- run=0 mid-MOVE for 10 ticks -> obs_left unchanged. After run=1, decrement resumes by 4 per tick.
- frame_tick asserted in the REQ cycle and again in the LOAD cycle -> both dropped; obs_left=1280 in MOVE until the next tick.
- reset asserted mid-MOVE with frame_tick high -> the next cycle shows the IDLE reset values and no scored pulse.
